num_lock: RTL and testbench
===========================

NUM_LOCK -- requirements
Module: num_lock

Interface
REQ-001 Parameter: CODE, 12'h123, expected digits {iNum1,iNum2,iNum3}, one BCD nibble each.
REQ-002 Parameter: OPEN_CYCLES, 16, number of CLK cycles the lock stays open.
REQ-003 Parameter: FAIL_CYCLES, 8, number of CLK cycles the fail indication is held.
REQ-004 Parameter: LOCK_CYCLES, 64, length of the lockout period in CLK cycles.
REQ-005 Parameter: MAX_TRIES, 3, consecutive failures that trigger lockout; range 1..3.
REQ-006 Port: CLK  input  1  system clock; all state is updated on its rising edge.
REQ-007 Port: reset  input  1  asynchronous, active-high reset.
REQ-008 Port: iNum1, iNum2, iNum3  input  4 each  digit values from the PS/2 keypad stage; stable while iNumRdy is high.
REQ-009 Port: iNumRdy  input  1  level ready flag from the keypad stage; only its rising edge is an event.
REQ-010 Port: oLED  output  3  status: 001 open, 010 fail, 100 lockout, 000 idle.
REQ-011 Port: oUnlock  output  1  high for exactly the OPEN state.
REQ-012 Port: oTries  output  2  count of consecutive failures.
REQ-013 Port: oBusy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL register iNumRdy once and detect an event when the current sample is high and the previous sample is low.
REQ-015 State machine states SHALL be IDLE, CHECK, OPEN, FAIL and LOCKOUT.
REQ-016 An event in IDLE SHALL latch the three digits and move to CHECK on the next cycle.
REQ-017 Events in any state other than IDLE SHALL be dropped, not queued.
REQ-018 CHECK SHALL last one cycle; the state after it, and its outputs, SHALL be visible 2 cycles after the event cycle.
REQ-019 A match in CHECK SHALL lead to OPEN: oUnlock=1, oLED=001, oTries cleared to 0.
REQ-020 Any latched digit greater than 9 SHALL be treated as a mismatch.
REQ-021 A mismatch in CHECK SHALL increment oTries, saturating at MAX_TRIES.
REQ-022 A mismatch that leaves oTries below MAX_TRIES SHALL lead to FAIL with oLED=010.
REQ-023 OPEN, FAIL and LOCKOUT SHALL each last exactly OPEN_CYCLES, FAIL_CYCLES and LOCK_CYCLES cycles respectively, then return to IDLE.
REQ-024 The dwell timer SHALL load N-1 on entry, decrement each cycle, and exit the state on the cycle it reads 0.
REQ-025 The timer width SHALL be $clog2 of the largest of the three cycle parameters.
REQ-026 An event that coincides with the last cycle of a timed state SHALL be ignored.
REQ-027 A rising edge that arrives while the block is busy and whose level is still high when IDLE is re-entered SHALL NOT count as an event.
REQ-028 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-029 Asserting reset SHALL asynchronously force: state IDLE, oLED=000, oUnlock=0, oTries=0, oBusy=0, timer 0, latched digits 0.
REQ-030 Asserting reset SHALL set the iNumRdy history register to 1, so a level already high at release is not an event.
REQ-031 Reset in mid-operation SHALL abort the sequence with no residual outputs.

Configuration
REQ-032 Macro NUM_LOCK_LOCKOUT_EN defined: a mismatch that brings oTries to MAX_TRIES SHALL lead to LOCKOUT (oLED=100); oTries SHALL clear on LOCKOUT exit.
REQ-033 Macro NUM_LOCK_LOCKOUT_EN undefined: the LOCKOUT state and its timer load SHALL be absent; every mismatch SHALL lead to FAIL; oTries SHALL saturate at MAX_TRIES.

Structure
REQ-034 Package num_lock_pkg SHALL hold the state enum, the DIGIT_W=4 constant and the LED codes LED_IDLE, LED_OPEN, LED_FAIL and LED_LOCK.
REQ-035 One sub-module SHALL exist: num_lock_timer, a loadable down-counter with a zero flag.

Verification
REQ-036 Digits 1,2,3 with a rising iNumRdy -> oUnlock=1, oLED=001 two cycles later, held for 16 cycles, then IDLE.
REQ-037 Digits 1,2,4 -> oLED=010, oTries=1 for 8 cycles; a second wrong entry -> oTries=2.
REQ-038 Three wrong entries with LOCKOUT_EN -> oLED=100 for 64 cycles, entry 1,2,3 during lockout ignored, oTries=0 afterwards.
REQ-039 Same as REQ-038 without LOCKOUT_EN -> third entry gives FAIL, oTries=3; entry 1,2,3 then opens and clears oTries.
REQ-040 Digits 1,2,A -> FAIL; iNumRdy held high across IDLE re-entry -> no second check.
REQ-041 Reset asserted in the 5th cycle of OPEN -> all outputs 0 immediately, independent of CLK.

Source files
------------

// File: rtl/num_lock_pkg.sv
// num_lock_pkg -- shared definitions for the keypad combination lock.
//   DIGIT_W      : width of one BCD digit
//   LED_*        : status codes shown on oLED
//   state_t      : controller states (LOCKOUT exists only when
//                  NUM_LOCK_LOCKOUT_EN is defined)
//   digit_valid  : true for a legal decimal digit 0..9
//   max3         : largest of three integers, used to size the dwell timer
package num_lock_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [2:0] LED_IDLE = 3'b000;
    localparam logic [2:0] LED_OPEN = 3'b001;
    localparam logic [2:0] LED_FAIL = 3'b010;
    localparam logic [2:0] LED_LOCK = 3'b100;

`ifdef NUM_LOCK_LOCKOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_OPEN, ST_FAIL, ST_LOCKOUT
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_OPEN, ST_FAIL
    } state_t;
`endif

    function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
        return (d <= DIGIT_W'(9));
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/num_lock_if.sv
// num_lock_if -- keypad-side and status-side signals of the combination lock.
//   iNum1..iNum3 : digits from the keypad stage (stable while iNumRdy is high)
//   iNumRdy      : level ready flag; its rising edge is the entry event
//   oLED         : status code (open / fail / lockout / idle)
//   oUnlock      : high while the lock is open
//   oTries       : consecutive failure count
//   oBusy        : high whenever the controller is not idle
// Modports: master drives the digits (keypad / bench), slave is the lock.
interface num_lock_if;
    import num_lock_pkg::*;

    logic [DIGIT_W-1:0] iNum1;
    logic [DIGIT_W-1:0] iNum2;
    logic [DIGIT_W-1:0] iNum3;
    logic               iNumRdy;
    logic [2:0]         oLED;
    logic               oUnlock;
    logic [1:0]         oTries;
    logic               oBusy;

    modport master (
        output iNum1, iNum2, iNum3, iNumRdy,
        input  oLED, oUnlock, oTries, oBusy
    );

    modport slave (
        input  iNum1, iNum2, iNum3, iNumRdy,
        output oLED, oUnlock, oTries, oBusy
    );

endinterface

// File: rtl/num_lock_timer.sv
// num_lock_timer -- loadable down-counter that stops at zero.
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_value this cycle (has priority over counting)
//   load_value : value to load
//   zero       : high while the count reads 0
module num_lock_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    // Count down to zero and hold there until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/num_lock.sv
// num_lock -- three-digit keypad combination lock.
//   CLK    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : num_lock_if slave (digits, ready flag, status outputs)
// A rising edge of iNumRdy while idle latches the digits; one CHECK cycle
// later the lock opens, or records a failure, for a fixed dwell time.
// Optional feature macro: NUM_LOCK_LOCKOUT_EN -- reaching MAX_TRIES
// failures enters a timed LOCKOUT instead of FAIL.
module num_lock
    import num_lock_pkg::*;
#(
    parameter logic [11:0] CODE        = 12'h123,
    parameter int          OPEN_CYCLES = 16,
    parameter int          FAIL_CYCLES = 8,
    parameter int          LOCK_CYCLES = 64,
    parameter int          MAX_TRIES   = 3
) (
    input  logic       CLK,
    input  logic       reset,
    num_lock_if.slave  bus
);

    localparam int MAX_CYC = max3(OPEN_CYCLES, FAIL_CYCLES, LOCK_CYCLES);
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] FAIL_LOAD = TW'(FAIL_CYCLES - 1);
`ifdef NUM_LOCK_LOCKOUT_EN
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
`endif
    localparam logic [1:0] TRIES_MAX = 2'(MAX_TRIES);

    state_t             state;
    logic               rdy_q;
    logic [DIGIT_W-1:0] num1_q, num2_q, num3_q;
    logic [2:0]         led_q;
    logic               unlock_q;
    logic [1:0]         tries_q;
    logic               busy_q;

    logic               entry_event;
    logic               code_ok;
    logic [1:0]         tries_inc;
    logic               go_lock;
    logic               timer_load;
    logic [TW-1:0]      timer_value;
    logic               timer_zero;

    // The history register resets high so a level already asserted when
    // reset releases is not mistaken for a fresh entry.
    assign entry_event = bus.iNumRdy & ~rdy_q;

    // Out-of-range digits can never match, even if CODE were to hold one.
    assign code_ok = digit_valid(num1_q) && digit_valid(num2_q) &&
                     digit_valid(num3_q) && ({num1_q, num2_q, num3_q} == CODE);

    assign tries_inc = (tries_q >= TRIES_MAX) ? TRIES_MAX : tries_q + 2'd1;

`ifdef NUM_LOCK_LOCKOUT_EN
    assign go_lock = (tries_inc == TRIES_MAX);
`else
    assign go_lock = 1'b0;
`endif

    // The dwell timer is loaded on the same edge that leaves CHECK, so the
    // timed state starts with N-1 and exits on the cycle it reads zero.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        if (state == ST_CHECK) begin
            timer_load = 1'b1;
            if (code_ok) begin
                timer_value = OPEN_LOAD;
`ifdef NUM_LOCK_LOCKOUT_EN
            end else if (go_lock) begin
                timer_value = LOCK_LOAD;
`endif
            end else begin
                timer_value = FAIL_LOAD;
            end
        end
    end

    num_lock_timer #(
        .W (TW)
    ) u_timer (
        .clk        (CLK),
        .rst        (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Controller with registered status outputs; events outside IDLE are
    // simply not looked at, which drops them.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rdy_q    <= 1'b1;
            num1_q   <= '0;
            num2_q   <= '0;
            num3_q   <= '0;
            led_q    <= LED_IDLE;
            unlock_q <= 1'b0;
            tries_q  <= 2'd0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= bus.iNumRdy;
            case (state)
                ST_IDLE: begin
                    if (entry_event) begin
                        num1_q <= bus.iNum1;
                        num2_q <= bus.iNum2;
                        num3_q <= bus.iNum3;
                        busy_q <= 1'b1;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (code_ok) begin
                        state    <= ST_OPEN;
                        led_q    <= LED_OPEN;
                        unlock_q <= 1'b1;
                        tries_q  <= 2'd0;
`ifdef NUM_LOCK_LOCKOUT_EN
                    end else if (go_lock) begin
                        state   <= ST_LOCKOUT;
                        led_q   <= LED_LOCK;
                        tries_q <= tries_inc;
`endif
                    end else begin
                        state   <= ST_FAIL;
                        led_q   <= LED_FAIL;
                        tries_q <= tries_inc;
                    end
                end
                ST_OPEN, ST_FAIL: begin
                    if (timer_zero) begin
                        state    <= ST_IDLE;
                        led_q    <= LED_IDLE;
                        unlock_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
`ifdef NUM_LOCK_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (timer_zero) begin
                        state   <= ST_IDLE;
                        led_q   <= LED_IDLE;
                        tries_q <= 2'd0;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state    <= ST_IDLE;
                    led_q    <= LED_IDLE;
                    unlock_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oLED    = led_q;
    assign bus.oUnlock = unlock_q;
    assign bus.oTries  = tries_q;
    assign bus.oBusy   = busy_q;

endmodule

// File: tb/tb_num_lock.sv
// tb_num_lock -- directed self-checking bench for num_lock.
// Expected status after each entry, and the idle state after its dwell,
// are queued when the entry is applied and popped when the DUT shows them.
// Honours NUM_LOCK_LOCKOUT_EN for the third-failure scenario.
module tb_num_lock;

    typedef struct {
        logic [2:0] led;
        logic       unlock;
        logic [1:0] tries;
        logic       busy;
    } exp_t;

    logic CLK;
    logic reset;
    int   checkCount = 0;
    int   errorCount = 0;
    exp_t  sbQ[$];
    string tagQ[$];

    num_lock_if bus ();

    num_lock dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic popCompare();
        exp_t  e;
        string t;
        if (sbQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $error("[TB] FAIL sb_underflow observed=empty expected=entry");
        end else begin
            e = sbQ.pop_front();
            t = tagQ.pop_front();
            checkOutput({t, "_led"},    32'(bus.oLED),    32'(e.led));
            checkOutput({t, "_unlock"}, 32'(bus.oUnlock), 32'(e.unlock));
            checkOutput({t, "_tries"},  32'(bus.oTries),  32'(e.tries));
            checkOutput({t, "_busy"},   32'(bus.oBusy),   32'(e.busy));
        end
    endtask

    // Drives one entry, checks the CHECK cycle, then the result two edges
    // after the event edge. hold keeps iNumRdy high afterwards.
    task automatic applyStimulus(input string tag, input logic [3:0] d1, input logic [3:0] d2,
                                 input logic [3:0] d3, input bit hold,
                                 input exp_t active, input exp_t idleAfter);
        sbQ.push_back(active);    tagQ.push_back(tag);
        sbQ.push_back(idleAfter); tagQ.push_back({tag, "_idle"});
        @(negedge CLK);
        bus.iNum1 = d1; bus.iNum2 = d2; bus.iNum3 = d3;
        bus.iNumRdy = 1'b1;
        @(posedge CLK); #1;
        checkOutput({tag, "_chk_busy"}, 32'(bus.oBusy), 32'd1);
        checkOutput({tag, "_chk_led"},  32'(bus.oLED),  32'd0);
        if (!hold) bus.iNumRdy = 1'b0;
        @(posedge CLK); #1;
        popCompare();
    endtask

    // Counts how many cycles oLED keeps showing led (the first is already
    // visible); optionally raises iNumRdy with 1,2,3 once cnt == pulseAt.
    task automatic measureDwell(input string tag, input logic [2:0] led,
                                input int expCycles, input int pulseAt);
        int cnt  = 1;
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (cnt == pulseAt) begin
                bus.iNum1 = 4'd1; bus.iNum2 = 4'd2; bus.iNum3 = 4'd3;
                bus.iNumRdy = 1'b1;
            end
            @(posedge CLK); #1;
            if (bus.oLED === led) cnt++;
            else done = 1'b1;
        end
        if (pulseAt >= 0) bus.iNumRdy = 1'b0;
        checkOutput({tag, "_dwell"}, 32'(cnt), 32'(expCycles));
        popCompare();
    endtask

    task automatic checkStaysIdle(input string tag, input int cycles);
        repeat (cycles) @(posedge CLK);
        #1;
        checkOutput({tag, "_busy"}, 32'(bus.oBusy), 32'd0);
        checkOutput({tag, "_led"},  32'(bus.oLED),  32'd0);
    endtask

    initial begin
        exp_t eOpen, eIdle;
        reset = 1'b1;
        bus.iNum1 = '0; bus.iNum2 = '0; bus.iNum3 = '0;
        bus.iNumRdy = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_led",    32'(bus.oLED),    32'd0);
        checkOutput("rst_unlock", 32'(bus.oUnlock), 32'd0);
        checkOutput("rst_tries",  32'(bus.oTries),  32'd0);
        checkOutput("rst_busy",   32'(bus.oBusy),   32'd0);
        reset = 1'b0;
        repeat (2) @(posedge CLK);

        // Correct code opens for 16 cycles.
        eOpen = '{led: 3'b001, unlock: 1'b1, tries: 2'd0, busy: 1'b1};
        eIdle = '{led: 3'b000, unlock: 1'b0, tries: 2'd0, busy: 1'b0};
        applyStimulus("open1", 4'd1, 4'd2, 4'd3, 1'b0, eOpen, eIdle);
        measureDwell("open1", 3'b001, 16, -1);

        // Two wrong entries; the second also pulses on its last FAIL cycle.
        applyStimulus("fail1", 4'd1, 4'd2, 4'd4, 1'b0,
                      '{led: 3'b010, unlock: 1'b0, tries: 2'd1, busy: 1'b1},
                      '{led: 3'b000, unlock: 1'b0, tries: 2'd1, busy: 1'b0});
        measureDwell("fail1", 3'b010, 8, -1);
        applyStimulus("fail2", 4'd1, 4'd2, 4'd4, 1'b0,
                      '{led: 3'b010, unlock: 1'b0, tries: 2'd2, busy: 1'b1},
                      '{led: 3'b000, unlock: 1'b0, tries: 2'd2, busy: 1'b0});
        measureDwell("fail2", 3'b010, 8, 8);
        checkStaysIdle("lastcyc", 3);

`ifdef NUM_LOCK_LOCKOUT_EN
        // Third failure locks out; a correct entry during lockout is ignored.
        applyStimulus("fail3", 4'd1, 4'd2, 4'd4, 1'b0,
                      '{led: 3'b100, unlock: 1'b0, tries: 2'd3, busy: 1'b1},
                      '{led: 3'b000, unlock: 1'b0, tries: 2'd0, busy: 1'b0});
        measureDwell("lock", 3'b100, 64, 10);
        checkStaysIdle("lock_after", 3);
`else
        // Third failure saturates at 3; a correct entry then clears it.
        applyStimulus("fail3", 4'd1, 4'd2, 4'd4, 1'b0,
                      '{led: 3'b010, unlock: 1'b0, tries: 2'd3, busy: 1'b1},
                      '{led: 3'b000, unlock: 1'b0, tries: 2'd3, busy: 1'b0});
        measureDwell("fail3", 3'b010, 8, -1);
        applyStimulus("open2", 4'd1, 4'd2, 4'd3, 1'b0, eOpen, eIdle);
        measureDwell("open2", 3'b001, 16, -1);
`endif

        // Non-BCD digit fails; the level held across IDLE re-entry is no event.
        applyStimulus("nonbcd", 4'd1, 4'd2, 4'hA, 1'b1,
                      '{led: 3'b010, unlock: 1'b0, tries: 2'd1, busy: 1'b1},
                      '{led: 3'b000, unlock: 1'b0, tries: 2'd1, busy: 1'b0});
        measureDwell("nonbcd", 3'b010, 8, -1);
        checkStaysIdle("held", 4);
        bus.iNumRdy = 1'b0;
        @(posedge CLK);

        // Reset in the 5th OPEN cycle clears everything without a clock edge.
        applyStimulus("rstmid", 4'd1, 4'd2, 4'd3, 1'b0, eOpen, eIdle);
        repeat (4) @(posedge CLK);
        #2;
        reset = 1'b1;
        #1;
        popCompare();
        @(negedge CLK);
        reset = 1'b0;
        checkStaysIdle("rstmid_after", 2);

        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
